// File: rtl/irq_pkg.sv
// Shared definitions for the four-line interrupt request front end.
// Holds the line count, the id width and the handshake FSM state type.
package irq_pkg;

  // Number of request lines handled by the front end.
  localparam int NUM_LINES = 4;

  // Width of the presented line index.
  localparam int ID_W = 2;

  // Handshake states:
  //   IDLE   - looking for an eligible pending line
  //   ASSERT - irq held high with a frozen irq_id until ack
  //   GAP    - one quiet cycle so the retired pending bit settles
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line flop synchroniser followed by a rising-edge detector.
// 'level' is the last synchroniser stage; 'rise' is high for exactly one
// clock when 'level' goes from 0 to 1.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] chain_q;
      logic                   prev_q;

      // Shift the raw line through the synchroniser and keep the previous
      // synchronised level for edge detection.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain_q <= '0;
          prev_q  <= 1'b0;
        end else begin
          chain_q <= (chain_q << 1) | SYNC_STAGES'(async_in[gi]);
          prev_q  <= chain_q[SYNC_STAGES-1];
        end
      end

      assign level[gi] = chain_q[SYNC_STAGES-1];
      assign rise[gi]  = chain_q[SYNC_STAGES-1] & ~prev_q;
    end
  endgenerate

endmodule

// File: rtl/irq_request_latch_4.sv
// Four-line interrupt request latch with irq/ack handshake.
// Raw requests are synchronised, rising edges are captured into a sticky
// pending vector (which also feeds the downstream priority encoder), and the
// highest-priority unmasked pending line is presented on irq/irq_id until
// acknowledged. Bit 3 has the highest priority.
// Optional build macro IRQ_LEVEL_EN switches capture to level-sensitive mode:
// pending follows the synchronised level, ack does not clear it and the
// overrun flags are tied low.
module irq_request_latch_4
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] req_lines,
  input  logic [NUM_LINES-1:0] mask_lines,
  input  logic                 ack,
  input  logic                 clr_overrun,
  output logic [NUM_LINES-1:0] pending_lines,
  output logic                 irq,
  output logic [ID_W-1:0]      irq_id,
  output logic [NUM_LINES-1:0] overrun_lines
);

  // Index of the highest set bit; 0 when the vector is empty (callers only
  // use the result when at least one bit is set).
  function automatic logic [ID_W-1:0] pick_highest(input logic [NUM_LINES-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  logic [NUM_LINES-1:0] sync_level;
  logic [NUM_LINES-1:0] sync_rise;
  logic [NUM_LINES-1:0] pending_q;
  logic [NUM_LINES-1:0] pending_d;
  logic [NUM_LINES-1:0] retire_vec;
  logic [NUM_LINES-1:0] elig;
  irq_state_t           state_q;
  irq_state_t           state_d;
  logic [ID_W-1:0]      irq_id_q;
  logic [ID_W-1:0]      irq_id_d;

  irq_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (NUM_LINES)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (req_lines),
    .level    (sync_level),
    .rise     (sync_rise)
  );

  // Lines that may be picked for presentation. Masked lines still capture.
  assign elig = pending_q & ~mask_lines;

  // One-hot retire strobe: the presented line being acknowledged this clock.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_retire
      assign retire_vec[gi] = (state_q == ASSERT) && ack && (irq_id_q == ID_W'(gi));
    end
  endgenerate

`ifdef IRQ_LEVEL_EN
  // Level mode: pending mirrors the synchronised level, one clock later.
  // The edge and retire strobes play no part here.
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_pend_lvl
      assign pending_d[gi] = sync_level[gi];
    end
  endgenerate

  assign overrun_lines = '0;
`else
  logic [NUM_LINES-1:0] overrun_q;
  logic [NUM_LINES-1:0] overrun_d;
  logic [NUM_LINES-1:0] new_overrun;

  // Edge mode: a new edge sets pending and beats a same-cycle retire, so an
  // event arriving exactly at acknowledge time is kept. An edge on a line
  // that stays pending is an overrun, which also beats clr_overrun.
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_pend_edge
      assign new_overrun[gi] = sync_rise[gi] & pending_q[gi] & ~retire_vec[gi];
      assign pending_d[gi]   = sync_rise[gi] | (pending_q[gi] & ~retire_vec[gi]);
      assign overrun_d[gi]   = new_overrun[gi] | (overrun_q[gi] & ~clr_overrun);
    end
  endgenerate

  // Sticky overrun flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_lines = overrun_q;
`endif

  // Pending vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // FSM state and presented-id registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
    end
  end

  // Next-state logic. The id is latched only on entry to ASSERT, so a
  // higher-priority arrival or a mask change never alters a live request.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      IDLE: begin
        if (elig != '0) begin
          state_d  = ASSERT;
          irq_id_d = pick_highest(elig);
        end
      end
      ASSERT: begin
        if (ack) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: irq is high exactly while a request is being presented.
  always_comb begin
    irq = (state_q == ASSERT);
  end

  assign irq_id        = irq_id_q;
  assign pending_lines = pending_q;

endmodule
